// File: rtl/ray_pixel_scheduler_pkg.sv
// ray_pixel_scheduler_pkg
//   Shared types and constants for the ray-marcher frame sequencer.
//   fp                  : 32-bit Q11.21 fixed-point word used by the datapath.
//   FP_FRAC_BITS_SCREEN : fraction bits of a screen coordinate.
//   sched_state_t       : frame sequencer states.
//   screen_coord()      : integer pixel index -> Q11.21 word with zero fraction.
package ray_pixel_scheduler_pkg;

   typedef logic [31:0] fp;

   localparam int FP_FRAC_BITS_SCREEN = 21;
   localparam int FP_INT_BITS_SCREEN  = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   function automatic fp screen_coord(input logic [FP_INT_BITS_SCREEN-1:0] c);
      return {c, {FP_FRAC_BITS_SCREEN{1'b0}}};
   endfunction

endpackage

// File: rtl/ray_pixel_scheduler_if.sv
// ray_pixel_scheduler_if
//   Pixel issue / result return bus between the scheduler and the datapath.
//   px_x, px_y   : Q11.21 screen coordinates of the offered pixel.
//   px_sof       : offered pixel is (0,0).
//   px_eol       : offered pixel is the last of its line.
//   px_valid     : pixel offered; px_ready accepts it.
//   res_valid    : datapath returned one result.
//   sdf_sel      : scene select held constant for the whole frame.
//   master = scheduler side, slave = datapath side.
interface ray_pixel_scheduler_if;
   import ray_pixel_scheduler_pkg::*;

   fp    px_x;
   fp    px_y;
   logic px_sof;
   logic px_eol;
   logic px_valid;
   logic px_ready;
   logic res_valid;
   logic sdf_sel;

   modport master (
      output px_x, px_y, px_sof, px_eol, px_valid, sdf_sel,
      input  px_ready, res_valid
   );

   modport slave (
      input  px_x, px_y, px_sof, px_eol, px_valid, sdf_sel,
      output px_ready, res_valid
   );

endinterface

// File: rtl/ray_pixel_scheduler_credit_counter.sv
// credit_counter
//   Up/down count of issued-but-unreturned pixels.
//   clk, rst  : clock, synchronous active-high reset.
//   inc       : one pixel issued this cycle.
//   dec       : one result returned this cycle.
//   count     : current outstanding count (never exceeds MAX).
//   underflow : sticky, set by a return with nothing outstanding; cleared by rst.
module credit_counter #(
   parameter int MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] count,
   output logic       underflow
);

   localparam logic [7:0] MAX_CNT = 8'(MAX);

   logic [7:0] count_q, count_d;
   logic       underflow_q, underflow_d;

   always_comb begin
      count_d     = count_q;
      underflow_d = underflow_q;
      // Simultaneous inc and dec cancel and leave the count untouched.
      if (inc && !dec) begin
         if (count_q < MAX_CNT) begin
            count_d = count_q + 8'd1;
         end
      end else if (dec && !inc) begin
         if (count_q == 8'd0) begin
            underflow_d = 1'b1;
         end else begin
            count_d = count_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= 8'd0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   assign count     = count_q;
   assign underflow = underflow_q;

endmodule

// File: rtl/ray_pixel_scheduler.sv
// ray_pixel_scheduler
//   Frame sequencer for the ray-marcher datapath: walks the screen in raster
//   order, offers one pixel per valid/ready handshake, limits outstanding
//   pixels with a credit counter and reports frame completion.
//   clk, rst      : clock, synchronous active-high reset.
//   start         : level, starts a frame while idle.
//   stop          : pulse, aborts the frame after the current handshake.
//   continuous    : restart automatically after a clean frame.
//   sdf_sel_in    : scene select, captured at each frame start.
//   px            : pixel/result bus (master side).
//   inflight      : outstanding pixel count.
//   busy          : frame in progress (issuing or draining).
//   done          : one-cycle pulse at frame end.
//   aborted       : with done, frame was stopped early.
//   err_underflow : sticky, result returned with nothing outstanding.
//   frame_count   : completed (non-aborted) frames, wraps.
module ray_pixel_scheduler
   import ray_pixel_scheduler_pkg::*;
#(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  continuous,
   input  logic                  sdf_sel_in,
   ray_pixel_scheduler_if.master px,
   output logic [7:0]            inflight,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  err_underflow,
   output logic [15:0]           frame_count
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
   localparam logic [7:0]    MAX_CNT = 8'(MAX_INFLIGHT);

   sched_state_t  state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          sdf_sel_q, sdf_sel_d;
   logic          abort_q, abort_d;
   logic          hold_q, hold_d;
   logic [15:0]   frame_count_q, frame_count_d;

   logic px_valid;
   logic fire;
   logic last_px;

   // Once offered, a pixel stays offered until it is taken, even if the
   // credit count says no new pixel could be offered right now.
   assign px_valid = (state_q == ISSUE) && (hold_q || (inflight < MAX_CNT));
   assign fire     = px_valid && px.px_ready;
   assign last_px  = (x_q == X_LAST) && (y_q == Y_LAST);

   credit_counter #(
      .MAX (MAX_INFLIGHT)
   ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (fire),
      .dec       (px.res_valid),
      .count     (inflight),
      .underflow (err_underflow)
   );

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      sdf_sel_d     = sdf_sel_q;
      abort_d       = abort_q;
      hold_d        = px_valid && !fire;
      frame_count_d = frame_count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               sdf_sel_d = sdf_sel_in;
               x_d       = '0;
               y_d       = '0;
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            if (fire) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
            if (stop) begin
               abort_d = 1'b1;
            end
            // An abort waits for a pending offer to be taken; with nothing
            // offered it leaves at once.
            if (fire && last_px) begin
               state_d = DRAIN;
            end else if ((stop || abort_q) && (!px_valid || fire)) begin
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            if (inflight == 8'd0) begin
               state_d = DONE;
            end
         end

         DONE: begin
            abort_d = 1'b0;
            if (!abort_q) begin
               frame_count_d = frame_count_q + 16'd1;
            end
            if (continuous && !abort_q) begin
               sdf_sel_d = sdf_sel_in;
               x_d       = '0;
               y_d       = '0;
               state_d   = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         sdf_sel_q     <= 1'b0;
         abort_q       <= 1'b0;
         hold_q        <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         sdf_sel_q     <= sdf_sel_d;
         abort_q       <= abort_d;
         hold_q        <= hold_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign px.px_valid = px_valid;
   assign px.px_x     = screen_coord(FP_INT_BITS_SCREEN'(x_q));
   assign px.px_y     = screen_coord(FP_INT_BITS_SCREEN'(y_q));
   assign px.px_sof   = px_valid && (x_q == '0) && (y_q == '0);
   assign px.px_eol   = px_valid && (x_q == X_LAST);
   assign px.sdf_sel  = sdf_sel_q;

   assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign aborted     = (state_q == DONE) && abort_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
`timescale 1ns/1ps
module tb_ray_pixel_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 4x3 screen, two credits.
   logic        rst_a, start_a, stop_a, cont_a, sel_a;
   logic [7:0]  inflight_a;
   logic        busy_a, done_a, aborted_a, err_a;
   logic [15:0] fc_a;
   ray_pixel_scheduler_if ifa();

   ray_pixel_scheduler #(.WIDTH(4), .HEIGHT(3), .MAX_INFLIGHT(2)) dut_a (
      .clk           (clk),
      .rst           (rst_a),
      .start         (start_a),
      .stop          (stop_a),
      .continuous    (cont_a),
      .sdf_sel_in    (sel_a),
      .px            (ifa),
      .inflight      (inflight_a),
      .busy          (busy_a),
      .done          (done_a),
      .aborted       (aborted_a),
      .err_underflow (err_a),
      .frame_count   (fc_a)
   );

   // Instance B: 4x3 screen, one credit, continuous mode.
   logic        rst_b, start_b, stop_b, cont_b, sel_b;
   logic [7:0]  inflight_b;
   logic        busy_b, done_b, aborted_b, err_b;
   logic [15:0] fc_b;
   ray_pixel_scheduler_if ifb();

   ray_pixel_scheduler #(.WIDTH(4), .HEIGHT(3), .MAX_INFLIGHT(1)) dut_b (
      .clk           (clk),
      .rst           (rst_b),
      .start         (start_b),
      .stop          (stop_b),
      .continuous    (cont_b),
      .sdf_sel_in    (sel_b),
      .px            (ifb),
      .inflight      (inflight_b),
      .busy          (busy_b),
      .done          (done_b),
      .aborted       (aborted_b),
      .err_underflow (err_b),
      .frame_count   (fc_b)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int          fires_a;
   int          exp_inf_a;
   logic [2:0]  sr_a, sr_b;
   logic        auto_a, auto_b;
   logic [31:0] rec_x [16];
   logic [31:0] rec_y [16];
   logic        rec_sof [16];
   logic        rec_eol [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: note handshakes seen before the edge, advance, then update
   // the bench's own return model (results come back 3 edges after a fire).
   task automatic tick();
      logic        fa, fb, ra;
      logic [31:0] cx, cy;
      logic        csof, ceol;
      fa   = (ifa.px_valid === 1'b1) && (ifa.px_ready === 1'b1);
      fb   = (ifb.px_valid === 1'b1) && (ifb.px_ready === 1'b1);
      ra   = (ifa.res_valid === 1'b1);
      cx   = ifa.px_x;
      cy   = ifa.px_y;
      csof = ifa.px_sof;
      ceol = ifa.px_eol;
      @(posedge clk);
      #1;
      if (fa) begin
         if (fires_a < 16) begin
            rec_x[fires_a]   = cx;
            rec_y[fires_a]   = cy;
            rec_sof[fires_a] = csof;
            rec_eol[fires_a] = ceol;
         end
         fires_a++;
      end
      if (fa && !ra) exp_inf_a++;
      else if (ra && !fa && exp_inf_a > 0) exp_inf_a--;
      sr_a = {sr_a[1:0], fa};
      sr_b = {sr_b[1:0], fb};
      if (auto_a) ifa.res_valid = sr_a[2];
      if (auto_b) ifb.res_valid = sr_b[2];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before the end of the test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got_done, got_ab;
      logic [31:0] hx, hy;
      int done_cnt, ab_cnt;

      rst_a = 1; start_a = 0; stop_a = 0; cont_a = 0; sel_a = 0;
      rst_b = 1; start_b = 0; stop_b = 0; cont_b = 0; sel_b = 0;
      ifa.px_ready = 0; ifa.res_valid = 0;
      ifb.px_ready = 0; ifb.res_valid = 0;
      auto_a = 0; auto_b = 0; sr_a = 0; sr_b = 0;
      fires_a = 0; exp_inf_a = 0;
      tick(); tick();

      // Reset state.
      chk("rst_valid",    ifa.px_valid, 0);
      chk("rst_sof",      ifa.px_sof,   0);
      chk("rst_eol",      ifa.px_eol,   0);
      chk("rst_busy",     busy_a,       0);
      chk("rst_done",     done_a,       0);
      chk("rst_aborted",  aborted_a,    0);
      chk("rst_sdf",      ifa.sdf_sel,  0);
      chk("rst_err",      err_a,        0);
      chk("rst_inflight", inflight_a,   0);
      chk("rst_fc",       fc_a,         0);
      rst_a = 0; rst_b = 0;

      // Basic frame: ready always, results back 3 edges after each fire.
      sel_a = 1; ifa.px_ready = 1; auto_a = 1; sr_a = 0; start_a = 1;
      tick();
      start_a = 0;
      chk("bf_first_valid", ifa.px_valid, 1);
      chk("bf_first_sof",   ifa.px_sof,   1);
      chk("bf_busy",        busy_a,       1);
      chk("bf_sdf",         ifa.sdf_sel,  1);
      done_cnt = 0; ab_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         chk("bf_inflight", inflight_a, 32'(exp_inf_a));
         if (done_a === 1'b1) done_cnt++;
         if (aborted_a === 1'b1) ab_cnt++;
      end
      chk("bf_fires",   fires_a,  12);
      chk("bf_done",    done_cnt, 1);
      chk("bf_aborted", ab_cnt,   0);
      chk("bf_fc",      fc_a,     1);
      chk("bf_idle",    busy_a,   0);
      for (int i = 0; i < 12; i++) begin
         chk("bf_x",   rec_x[i],   32'(i % 4) << 21);
         chk("bf_y",   rec_y[i],   32'(i / 4) << 21);
         chk("bf_sof", rec_sof[i], (i == 0) ? 1 : 0);
         chk("bf_eol", rec_eol[i], (i % 4 == 3) ? 1 : 0);
      end
      chk("bf_x_last", rec_x[11], 32'h0060_0000);
      chk("bf_y_last", rec_y[11], 32'h0040_0000);

      // Credit limit: no results returned.
      auto_a = 0; ifa.res_valid = 0; fires_a = 0; start_a = 1;
      tick();
      start_a = 0;
      for (int i = 0; i < 6; i++) tick();
      chk("cl_fires",    fires_a,      2);
      chk("cl_valid",    ifa.px_valid, 0);
      chk("cl_inflight", inflight_a,   2);
      ifa.res_valid = 1;
      tick();
      ifa.res_valid = 0;
      chk("cl_revalid",  ifa.px_valid, 1);
      chk("cl_inflight1", inflight_a,  1);
      // Fire and return on the same edge.
      ifa.res_valid = 1;
      tick();
      ifa.res_valid = 0;
      chk("cl_simul_fires",    fires_a,    3);
      chk("cl_simul_inflight", inflight_a, 1);

      // Reset mid-frame.
      rst_a = 1;
      tick();
      rst_a = 0;
      exp_inf_a = 0;
      chk("mr_busy",     busy_a,       0);
      chk("mr_valid",    ifa.px_valid, 0);
      chk("mr_inflight", inflight_a,   0);
      chk("mr_fc",       fc_a,         0);

      // Stop mid-frame with the 6th pixel held under backpressure.
      sel_a = 0; auto_a = 1; sr_a = 0; fires_a = 0; ifa.px_ready = 1; start_a = 1;
      tick();
      start_a = 0;
      for (int i = 0; i < 60; i++) begin
         ifa.px_ready = (fires_a < 5);
         tick();
         if (fires_a >= 5 && ifa.px_valid === 1'b1) break;
      end
      ifa.px_ready = 0;
      chk("st_fires5", fires_a,      5);
      chk("st_valid",  ifa.px_valid, 1);
      chk("st_hold_x", ifa.px_x,     32'h0020_0000);
      chk("st_hold_y", ifa.px_y,     32'h0020_0000);
      hx = ifa.px_x; hy = ifa.px_y;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", ifa.px_valid, 1);
         chk("bp_x",     ifa.px_x,     hx);
         chk("bp_y",     ifa.px_y,     hy);
         chk("bp_sof",   ifa.px_sof,   0);
      end
      chk("bp_fires", fires_a, 5);
      stop_a = 1;
      tick();
      stop_a = 0;
      chk("st_still_valid", ifa.px_valid, 1);
      chk("st_still_busy",  busy_a,       1);
      chk("st_still_x",     ifa.px_x,     32'h0020_0000);
      ifa.px_ready = 1;
      tick();
      chk("st_fires6",   fires_a,      6);
      chk("st_drain_v",  ifa.px_valid, 0);
      chk("st_drain_b",  busy_a,       1);
      got_done = 0; got_ab = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done_a === 1'b1) begin
            got_done = 1;
            got_ab   = aborted_a;
            break;
         end
      end
      chk("st_done",    got_done, 1);
      chk("st_aborted", got_ab,   1);
      chk("st_fc",      fc_a,     0);
      tick();
      chk("st_idle_busy",  busy_a,       0);
      chk("st_idle_valid", ifa.px_valid, 0);
      chk("st_idle_fc",    fc_a,         0);
      chk("st_fires_end",  fires_a,      6);

      // Underflow in IDLE, then reset clears it.
      auto_a = 0; ifa.res_valid = 1;
      tick();
      ifa.res_valid = 0;
      chk("uf_err",      err_a,      1);
      chk("uf_inflight", inflight_a, 0);
      tick();
      chk("uf_sticky",   err_a,      1);
      rst_a = 1;
      tick();
      rst_a = 0;
      chk("ur_err",      err_a,        0);
      chk("ur_valid",    ifa.px_valid, 0);
      chk("ur_busy",     busy_a,       0);
      chk("ur_done",     done_a,       0);
      chk("ur_aborted",  aborted_a,    0);
      chk("ur_sdf",      ifa.sdf_sel,  0);
      chk("ur_inflight", inflight_a,   0);
      chk("ur_fc",       fc_a,         0);

      // Continuous mode on the single-credit instance.
      cont_b = 1; sel_b = 0; auto_b = 1; sr_b = 0; ifb.px_ready = 1; start_b = 1;
      tick();
      start_b = 0;
      chk("cm_sdf0",  ifb.sdf_sel, 0);
      chk("cm_busy0", busy_b,      1);
      sel_b = 1;
      got_done = 0; got_ab = 1;
      for (int i = 0; i < 150; i++) begin
         tick();
         chk("cm_inflight_max", 32'(inflight_b <= 8'd1), 1);
         if (done_b === 1'b1) begin
            got_done = 1;
            got_ab   = aborted_b;
            break;
         end
      end
      chk("cm_done1",    got_done, 1);
      chk("cm_aborted1", got_ab,   0);
      tick();
      chk("cm_busy1",  busy_b,       1);
      chk("cm_sdf1",   ifb.sdf_sel,  1);
      chk("cm_fc1",    fc_b,         1);
      chk("cm_valid1", ifb.px_valid, 1);
      chk("cm_sof1",   ifb.px_sof,   1);
      sel_b = 0;
      got_done = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (done_b === 1'b1) begin
            got_done = 1;
            break;
         end
      end
      chk("cm_done2", got_done, 1);
      tick();
      chk("cm_fc2",   fc_b,        2);
      chk("cm_sdf2",  ifb.sdf_sel, 0);
      chk("cm_busy2", busy_b,      1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
